// File: rtl/lsu_pkg.sv
// Shared types and func3 encodings for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_legal_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_legal_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_align.sv
// Shifts the read word down to the accessed lane and sign/zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  // Lane select followed by size/sign extension.
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    case (func3)
      F3_B:    result = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    result = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    result = shifted_s;
      F3_BU:   result = {24'h000000, shifted_s[7:0]};
      F3_HU:   result = {16'h0000, shifted_s[15:0]};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one registered req/ack bus transaction per access,
// stalling the pipeline until the access completes, aborts, or is rejected.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        bus_err_q, bus_err_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        legal_s, aligned_s, access_s, accept_s, reject_s;
  logic        ack_s, timeout_s;
  logic [31:0] aligned_data_s;

  // Legality and alignment of the instruction currently in MEM; store wins over load.
  always_comb begin
    access_s = mem_rd_en | mem_wr_en;
    if (mem_wr_en) begin
      legal_s = is_legal_store(func3);
    end else begin
      legal_s = is_legal_load(func3);
    end
    case (func3[1:0])
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = ~addr[0];
      2'b10:   aligned_s = (addr[1:0] == 2'b00);
      default: aligned_s = 1'b0;
    endcase
    accept_s  = (state_q == IDLE) && access_s && legal_s && aligned_s;
    reject_s  = (state_q == IDLE) && access_s && !(legal_s && aligned_s);
    ack_s     = (state_q == BUSY) && bus_ack;
    timeout_s = (state_q == BUSY) && !bus_ack && (cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack in the last counted cycle still wins over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = BUSY;
        else          state_d = IDLE;
      end
      BUSY: begin
        if (ack_s || timeout_s) state_d = DONE;
        else                    state_d = BUSY;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pipeline-facing outputs; gated by rst_n so a reset releases the pipeline at once.
  always_comb begin
    stall      = rst_n & (accept_s | (state_q == BUSY));
    misaligned = rst_n & reject_s;
  end

  load_align u_load_align (
    .rdata  (bus_rdata),
    .offset (off_q),
    .func3  (func3_q),
    .result (aligned_data_s)
  );

  // Datapath next values: launch on accept, retire on ack or timeout.
  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    load_data_d = load_data_q;
    func3_d     = func3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    bus_err_d   = timeout_s;
    if (accept_s) begin
      bus_req_d  = 1'b1;
      bus_we_d   = mem_wr_en;
      bus_addr_d = {addr[31:2], 2'b00};
      func3_d    = func3;
      off_d      = addr[1:0];
      cnt_d      = {CNT_W{1'b0}};
      if (mem_wr_en) begin
        case (func3)
          F3_B: begin
            bus_be_d    = 4'b0001 << addr[1:0];
            bus_wdata_d = {4{wdata[7:0]}};
          end
          F3_H: begin
            bus_be_d    = 4'b0011 << {addr[1], 1'b0};
            bus_wdata_d = {2{wdata[15:0]}};
          end
          default: begin
            bus_be_d    = 4'hF;
            bus_wdata_d = wdata;
          end
        endcase
      end else begin
        bus_be_d    = 4'hF;
        bus_wdata_d = wdata;
      end
    end else if (ack_s) begin
      bus_req_d = 1'b0;
      cnt_d     = {CNT_W{1'b0}};
      if (bus_we_q) begin
        load_data_d = 32'h0000_0000;
      end else begin
        load_data_d = aligned_data_s;
      end
    end else if (timeout_s) begin
      bus_req_d   = 1'b0;
      cnt_d       = {CNT_W{1'b0}};
      load_data_d = 32'h0000_0000;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (reject_s) begin
      load_data_d = 32'h0000_0000;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0000_0000;
      load_data_q <= 32'h0000_0000;
      bus_err_q   <= 1'b0;
      func3_q     <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign load_data = load_data_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 4-cycle timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd_en, mem_wr_en;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic [31:0] load_data;
  logic        stall, misaligned, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .func3(func3), .addr(addr), .wdata(wdata), .load_data(load_data),
    .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One accepted access: accept cycle, busy cycles (ack on ack_cycle, 0 = never), DONE.
  task automatic xact(input string tag, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rdata, input int ack_cycle, input int busy_cycles,
                      input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                      input logic [31:0] exp_ld, input logic exp_err);
    @(negedge clk);
    mem_rd_en = rd; mem_wr_en = wr; func3 = f3; addr = a; wdata = wd;
    #1;
    chk({tag, ".acc_stall"}, {31'd0, stall}, 32'd1);
    chk({tag, ".acc_mis"}, {31'd0, misaligned}, 32'd0);
    chk({tag, ".acc_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, ".acc_err"}, {31'd0, bus_err}, 32'd0);
    for (int c = 1; c <= busy_cycles; c++) begin
      @(negedge clk);
      #1;
      chk({tag, ".busy_req"}, {31'd0, bus_req}, 32'd1);
      chk({tag, ".busy_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, ".busy_we"}, {31'd0, bus_we}, {31'd0, wr});
      chk({tag, ".busy_addr"}, bus_addr, {a[31:2], 2'b00});
      chk({tag, ".busy_be"}, {28'd0, bus_be}, {28'd0, exp_be});
      if (wr) chk({tag, ".busy_wdata"}, bus_wdata, exp_wdata);
      if (c == ack_cycle) begin
        bus_ack = 1'b1; bus_rdata = rdata;
      end else begin
        bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
      end
    end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".done_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, ".done_ld"}, load_data, exp_ld);
    chk({tag, ".done_err"}, {31'd0, bus_err}, {31'd0, exp_err});
  endtask

  // Illegal or misaligned access: pulse, no stall, no bus, load_data cleared.
  task automatic reject(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    mem_rd_en = rd; mem_wr_en = wr; func3 = f3; addr = a;
    #1;
    chk({tag, ".mis"}, {31'd0, misaligned}, 32'd1);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    @(negedge clk);
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    #1;
    chk({tag, ".req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, ".ld"}, load_data, 32'd0);
    chk({tag, ".mis_off"}, {31'd0, misaligned}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0; func3 = 3'b000;
    addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    @(negedge clk);
    #1;
    chk("rst.req", {31'd0, bus_req}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.ld", load_data, 32'd0);
    chk("rst.be", {28'd0, bus_be}, 32'd0);
    chk("rst.addr", bus_addr, 32'd0);
    chk("rst.err", {31'd0, bus_err}, 32'd0);
    rst_n = 1'b1;

    xact("lw",    1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("lb",    1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 2, 2, 4'hF, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("lbu",   1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1, 4'hF, 32'h0, 32'h00000080, 1'b0);
    xact("lhu",   1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 1, 1, 4'hF, 32'h0, 32'h0000BEEF, 1'b0);
    xact("lh",    1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 1, 1, 4'hF, 32'h0, 32'hFFFF8001, 1'b0);
    xact("sb",    1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h12345678, 1, 1, 4'b0010, 32'hABABABAB, 32'h0, 1'b0);
    xact("sh",    1'b0, 1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'h12345678, 1, 1, 4'b1100, 32'hCDEFCDEF, 32'h0, 1'b0);
    xact("sw_rw", 1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h12345678, 1, 1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("ack4",  1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'h11223344, 4, 4, 4'hF, 32'h0, 32'h11223344, 1'b0);

    // Non-memory cycle and a stray ack in IDLE: nothing changes.
    @(negedge clk);
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    #1;
    chk("nomem.stall", {31'd0, stall}, 32'd0);
    chk("nomem.err_gone", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("nomem.ld_hold", load_data, 32'h11223344);
    chk("nomem.req", {31'd0, bus_req}, 32'd0);

    reject("mis_lw", 1'b1, 1'b0, 3'b010, 32'h102);
    reject("mis_sh", 1'b0, 1'b1, 3'b001, 32'h101);
    reject("ill_ld", 1'b1, 1'b0, 3'b011, 32'h100);
    reject("ill_st", 1'b0, 1'b1, 3'b100, 32'h100);

    xact("lw_pre", 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h77665544, 1, 1, 4'hF, 32'h0, 32'h77665544, 1'b0);
    xact("tmo",    1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 4, 4'hF, 32'h0, 32'h0, 1'b1);

    // Reset while BUSY with the load still presented.
    @(negedge clk);
    mem_rd_en = 1'b1; mem_wr_en = 1'b0; func3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    #1;
    chk("rstb.req_before", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstb.req", {31'd0, bus_req}, 32'd0);
    chk("rstb.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    mem_rd_en = 1'b0; rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("rstb.late_ack_req", {31'd0, bus_req}, 32'd0);
    chk("rstb.late_ack_ld", load_data, 32'd0);
    xact("lw_post", 1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 32'h0A0B0C0D, 1, 1, 4'hF, 32'h0, 32'h0A0B0C0D, 1'b0);

    @(negedge clk);
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    #1;
    chk("end.stall", {31'd0, stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
